// File: rtl/mem_port_arbiter.sv
// Shares one single-ported memory between instruction fetch and data access, one transaction at a time.
// Optional ARB_ROUND_ROBIN_EN replaces fixed data-over-fetch priority with alternating priority on contention.
module mem_port_arbiter #(
  parameter int ADDR_W      = 32,
  parameter int DATA_W      = 32,
  parameter int TIMEOUT_CYC = 64
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              if_req_i,
  input  logic [ADDR_W-1:0] if_addr_i,
  output logic              if_ack_o,
  output logic [DATA_W-1:0] if_rdata_o,
  input  logic              dm_req_i,
  input  logic              dm_we_i,
  input  logic [ADDR_W-1:0] dm_addr_i,
  input  logic [DATA_W-1:0] dm_wdata_i,
  output logic              dm_ack_o,
  output logic [DATA_W-1:0] dm_rdata_o,
  output logic              mem_req_o,
  output logic              mem_we_o,
  output logic [ADDR_W-1:0] mem_addr_o,
  output logic [DATA_W-1:0] mem_wdata_o,
  input  logic              mem_ack_i,
  input  logic [DATA_W-1:0] mem_rdata_i,
  output logic [1:0]        grant_o,
  output logic              stall_o,
  output logic              err_o
);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_BUSY = 2'd1;
  localparam logic [1:0] ST_RESP = 2'd2;

  localparam int CNT_W = (TIMEOUT_CYC > 2) ? $clog2(TIMEOUT_CYC) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYC - 1);

  logic [1:0]        state_q, state_d;
  logic              own_dm_q, own_dm_d;
  logic              we_q, we_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [DATA_W-1:0] if_rdata_q, if_rdata_d;
  logic [DATA_W-1:0] dm_rdata_q, dm_rdata_d;
  logic              err_q, err_d;
  logic              pick_dm;

`ifdef ARB_ROUND_ROBIN_EN
  // Pointer records the winner of the last contested grant; reset value means fetch.
  logic rr_last_dm_q, rr_last_dm_d;

  assign pick_dm = dm_req_i & (~if_req_i | ~rr_last_dm_q);

  always_comb begin
    rr_last_dm_d = rr_last_dm_q;
    if (state_q == ST_IDLE && if_req_i && dm_req_i) rr_last_dm_d = pick_dm;
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) rr_last_dm_q <= 1'b0;
    else       rr_last_dm_q <= rr_last_dm_d;
  end
`else
  assign pick_dm = dm_req_i;
`endif

  always_comb begin
    state_d    = state_q;
    own_dm_d   = own_dm_q;
    we_d       = we_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    cnt_d      = cnt_q;
    if_rdata_d = if_rdata_q;
    dm_rdata_d = dm_rdata_q;
    err_d      = err_q;
    case (state_q)
      ST_IDLE: begin
        if (if_req_i || dm_req_i) begin
          state_d  = ST_BUSY;
          own_dm_d = pick_dm;
          we_d     = pick_dm & dm_we_i;
          addr_d   = pick_dm ? dm_addr_i : if_addr_i;
          wdata_d  = pick_dm ? dm_wdata_i : '0;
          cnt_d    = '0;
        end
      end
      ST_BUSY: begin
        // Ack takes precedence over a timeout landing on the same cycle.
        if (mem_ack_i) begin
          state_d = ST_RESP;
          if (!we_q) begin
            if (own_dm_q) dm_rdata_d = mem_rdata_i;
            else          if_rdata_d = mem_rdata_i;
          end
        end else if (cnt_q == CNT_LAST) begin
          state_d = ST_RESP;
          err_d   = 1'b1;
          if (own_dm_q) dm_rdata_d = '0;
          else          if_rdata_d = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      ST_RESP: begin
        state_d = ST_IDLE;
        cnt_d   = '0;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q    <= ST_IDLE;
      own_dm_q   <= 1'b0;
      we_q       <= 1'b0;
      addr_q     <= '0;
      wdata_q    <= '0;
      cnt_q      <= '0;
      if_rdata_q <= '0;
      dm_rdata_q <= '0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      own_dm_q   <= own_dm_d;
      we_q       <= we_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      cnt_q      <= cnt_d;
      if_rdata_q <= if_rdata_d;
      dm_rdata_q <= dm_rdata_d;
      err_q      <= err_d;
    end
  end

  assign mem_req_o   = (state_q == ST_BUSY);
  assign mem_we_o    = we_q;
  assign mem_addr_o  = addr_q;
  assign mem_wdata_o = wdata_q;
  assign grant_o     = (state_q == ST_IDLE) ? 2'b00 : {own_dm_q, ~own_dm_q};
  assign if_ack_o    = (state_q == ST_RESP) & ~own_dm_q;
  assign dm_ack_o    = (state_q == ST_RESP) & own_dm_q;
  assign if_rdata_o  = if_rdata_q;
  assign dm_rdata_o  = dm_rdata_q;
  assign err_o       = err_q;
  assign stall_o     = (if_req_i & ~if_ack_o) | (dm_req_i & ~dm_ack_o);

endmodule
